axi4lite_slave_regfile: RTL and testbench
=========================================

// Module: axi4lite_slave_regfile
// PURPOSE
//  AXI4-Lite slave register file: the DUT-side endpoint driven by the kb_axi4lite agent bus.
//  Accepts independent AW/W/AR transactions and returns BRESP/RRESP.
//  Exposes a bank of 32-bit byte-writable registers to core logic, plus write-notify pulses.
//  Unmapped addresses complete with SLVERR; the bus never hangs.
// PARAMETERS
//  N_REGS      16        number of 32-bit registers (1..256), word address 0..N_REGS-1
//  ADDR_W      32        AWADDR/ARADDR width; byte address, index = ADDR[9:2]
//  RST_VAL     32'h0     reset value of every register
// PORTS
//  ACLK         in   1            clock, all logic on rising edge
//  ARESET       in   1            synchronous reset, active-high
//  AWADDR       in   ADDR_W       write address
//  AWPROT       in   3            ignored
//  AWVALID      in   1            write address valid
//  AWREADY      out  1            write address ready
//  WDATA        in   32           write data
//  WSTRB        in   4            byte strobes, bit i enables WDATA[8i+7:8i]
//  WVALID/WREADY in/out 1         write data handshake
//  BRESP        out  2            2'b00 OKAY, 2'b10 SLVERR
//  BVALID/BREADY out/in 1         write response handshake
//  ARADDR       in   ADDR_W       read address
//  ARPROT       in   3            ignored
//  ARVALID/ARREADY in/out 1       read address handshake
//  RDATA        out  32           read data
//  RRESP        out  2            2'b00 OKAY, 2'b10 SLVERR
//  RVALID/RREADY out/in 1         read data handshake
//  reg_q        out  32*N_REGS    register contents, reg i at [32i+31:32i]
//  reg_wr       out  N_REGS       1-cycle pulse on the cycle after reg i was written
// BEHAVIOUR
//  Reset: AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, RVALID=0, BRESP=RRESP=0, RDATA=0,
//   reg_q=RST_VAL for all, reg_wr=0; write/read FSMs go to IDLE. Reset mid-transaction
//   aborts it silently; no partial write and no response is issued.
//  Write FSM states: W_IDLE, W_RESP.
//   W_IDLE: AW and W are each latched on their own handshake; after latching, that READY
//    drops to 0 until the response completes. Arrival order is free; both may arrive in one cycle.
//   When both are held at the start of a cycle, that edge commits the write and sets BVALID=1.
//    The FSM then enters W_RESP. Min latency: AW+W handshake edge t -> commit+BVALID edge t+1.
//   Commit: idx<N_REGS -> bytes with WSTRB=1 updated, reg_wr[idx]=1 for one cycle, BRESP=00.
//    idx>=N_REGS -> no register change, no pulse, BRESP=10. WSTRB=0 -> OKAY, no data change, pulse still issued.
//   W_RESP: BVALID held, BRESP stable until BREADY=1. On that edge, BVALID=0 and AWREADY=WREADY=1, then W_IDLE.
//    One outstanding write maximum.
//  Read FSM states: R_IDLE, R_DATA; fully independent of the write FSM.
//   R_IDLE: ARREADY=1. AR handshake at edge t -> edge t+1: RVALID=1, ARREADY=0, RDATA/RRESP registered.
//   RDATA = reg[idx] value present before edge t+1. A write committing on edge t+1 is not seen (old data).
//   idx>=N_REGS -> RDATA=0, RRESP=10.
//   R_DATA: RVALID, RDATA, RRESP held until RREADY=1. That edge drops RVALID, sets ARREADY=1 -> R_IDLE.
//  Address bits [1:0] and bits above [9:2] are ignored for decode, except ADDR>=4*N_REGS -> SLVERR.
//  VALID from the master may drop before handshake; only handshake edges have effect.
// TESTING
//  1 reset: drive ARESET=1 for 2 cycles -> all READY=1, BVALID=RVALID=0, reg_q all RST_VAL.
//  2 write 0x04=0xDEADBEEF with WSTRB=F, AW and W in the same cycle -> BVALID next cycle, BRESP=00.
//    reg_wr[1] pulses once; reading 0x04 returns 0xDEADBEEF, RRESP=00.
//  3 W before AW by 3 cycles; WSTRB=4'b0010, WDATA=0x0000AB00 to 0x04 -> reg1=0xDEADABEF, OKAY.
//  4 write/read addr 4*N_REGS -> BRESP=10, no reg_q change, no pulse; RDATA=0, RRESP=10.
//  5 hold BREADY=0 and RREADY=0 for 5 cycles -> BVALID/RVALID and data stable; AWREADY/WREADY/ARREADY=0.
//  6 same-cycle read+write of reg 2 (old 0x1, new 0x2) -> RDATA=0x1; next read 0x2.
//    Assert ARESET while in W_RESP -> BVALID=0, READY=1 next cycle.

Source files
------------

// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave exposing N_REGS byte-writable 32-bit registers to core logic.
// Independent write (AW/W -> B) and read (AR -> R) engines; unmapped addresses answer SLVERR.
module axi4lite_slave_regfile #(
    parameter int          N_REGS  = 16,
    parameter int          ADDR_W  = 32,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [2:0]          AWPROT,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [31:0]         WDATA,
    input  logic [3:0]          WSTRB,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [2:0]          ARPROT,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [31:0]         RDATA,
    output logic [1:0]          RRESP,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [32*N_REGS-1:0] reg_q,
    output logic [N_REGS-1:0]   reg_wr
);

    // state     | meaning
    // W_IDLE    | collecting AW and W, each latched on its own handshake
    // W_RESP    | write committed, BVALID held until BREADY
    // R_IDLE    | accepting AR; a latched address is served on the next edge
    // R_DATA    | RVALID/RDATA/RRESP held until RREADY
    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * N_REGS);
    localparam logic [1:0]      RESP_OKAY  = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;

    logic [31:0]       regs [N_REGS];
    logic              aw_held, w_held, ar_held;
    logic [ADDR_W-1:0] aw_addr, ar_addr;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              w_commit, r_capture;
    logic              w_err, r_err;
    logic [7:0]        w_idx, r_idx;
    logic [31:0]       rd_word;

    logic unused_prot;
    assign unused_prot = ^{AWPROT, ARPROT};

    assign w_err = ({1'b0, aw_addr} >= ADDR_LIMIT);
    assign r_err = ({1'b0, ar_addr} >= ADDR_LIMIT);
    assign w_idx = aw_addr[9:2];
    assign r_idx = ar_addr[9:2];

    assign AWREADY = ~aw_held;
    assign WREADY  = ~w_held;
    assign ARREADY = (r_state == R_IDLE) && !ar_held;
    assign BVALID  = (w_state == W_RESP);
    assign RVALID  = (r_state == R_DATA);

    always_comb begin
        w_next   = w_state;
        w_commit = 1'b0;
        case (w_state)
            W_IDLE: if (aw_held && w_held) begin
                w_commit = 1'b1;
                w_next   = W_RESP;
            end
            W_RESP: if (BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next    = r_state;
        r_capture = 1'b0;
        case (r_state)
            R_IDLE: if (ar_held) begin
                r_capture = 1'b1;
                r_next    = R_DATA;
            end
            R_DATA: if (RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Sampled before the edge, so a write committing on the capture edge is not visible.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (r_idx == 8'(i)) rd_word = regs[i];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            ar_held <= 1'b0;
            aw_addr <= '0;
            ar_addr <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            BRESP   <= RESP_OKAY;
            RRESP   <= RESP_OKAY;
            RDATA   <= '0;
            reg_wr  <= '0;
            for (int i = 0; i < N_REGS; i++) regs[i] <= RST_VAL;
        end else begin
            reg_wr <= '0;
            if (AWVALID && AWREADY) begin
                aw_held <= 1'b1;
                aw_addr <= AWADDR;
            end
            if (WVALID && WREADY) begin
                w_held  <= 1'b1;
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end
            if (w_commit) begin
                BRESP <= w_err ? RESP_SLVERR : RESP_OKAY;
                for (int i = 0; i < N_REGS; i++) begin
                    if (!w_err && w_idx == 8'(i)) begin
                        reg_wr[i] <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_q[b]) regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                    end
                end
            end
            if (w_state == W_RESP && BREADY) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (ARVALID && ARREADY) begin
                ar_held <= 1'b1;
                ar_addr <= ARADDR;
            end
            if (r_capture) begin
                ar_held <= 1'b0;
                RDATA   <= r_err ? 32'h0 : rd_word;
                RRESP   <= r_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_reg_q
        assign reg_q[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Bench for axi4lite_slave_regfile: vector table of writes/reads through a response scoreboard,
// plus hand-written sequences for simultaneous read/write and reset during a pending response.
module tb_axi4lite_slave_regfile;

    localparam int NR = 16;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [31:0]       AWADDR, WDATA, ARADDR;
    logic [2:0]        AWPROT, ARPROT;
    logic [3:0]        WSTRB;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]        BRESP, RRESP;
    logic [31:0]       RDATA;
    logic [32*NR-1:0]  reg_q;
    logic [NR-1:0]     reg_wr;

    axi4lite_slave_regfile #(.N_REGS(NR), .ADDR_W(32), .RST_VAL(32'h0)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_q(reg_q), .reg_wr(reg_wr)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        int          hold;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    exp_t        b_q[$];
    exp_t        r_q[$];
    logic [31:0] model [NR];
    int          pulse_cnt [NR];
    int          pulse_total = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    initial for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;

    always @(negedge ACLK) begin
        for (int i = 0; i < NR; i++) begin
            if (reg_wr[i]) begin
                pulse_cnt[i]++;
                pulse_total++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string name);
        logic [32*NR-1:0] exp_v;
        for (int i = 0; i < NR; i++) exp_v[32*i +: 32] = model[i];
        n_tests++;
        if (reg_q !== exp_v) begin
            n_fail++;
            $display("FAIL %s: reg_q got 0x%0h, expected 0x%0h", name, reg_q, exp_v);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, input int hold, input logic [1:0] exp_resp);
        logic a_hs, w_hs, aw_done, w_done, ok;
        int   lat, idx, tot0, cnt0;
        exp_t e;
        ok  = (addr < 32'(4 * NR));
        idx = int'(addr[9:2]);
        e.resp = exp_resp;
        e.data = 32'h0;
        b_q.push_back(e);
        if (ok) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
        tot0 = pulse_total;
        cnt0 = ok ? pulse_cnt[idx] : 0;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        aw_done = 1'b0; w_done = 1'b0;
        for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
            if (!aw_done && cyc >= (lead > 0 ? lead : 0)) AWVALID = 1'b1;
            if (!w_done && cyc >= (lead < 0 ? -lead : 0)) WVALID = 1'b1;
            a_hs = AWVALID && AWREADY;
            w_hs = WVALID && WREADY;
            @(negedge ACLK);
            if (a_hs) begin AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_hs) begin WVALID = 1'b0; w_done = 1'b1; end
            if (aw_done && !w_done) check("awready_low_while_waiting_w", 32'(AWREADY), 32'h0);
            if (w_done && !aw_done) check("wready_low_while_waiting_aw", 32'(WREADY), 32'h0);
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        check("aw_w_handshake", 32'({aw_done, w_done}), 32'h3);
        lat = 0;
        while (!BVALID && lat < 20) begin
            @(negedge ACLK);
            lat++;
        end
        check("b_latency", 32'(lat), 32'd1);
        if (b_q.size() > 0) begin
            e = b_q.pop_front();
            check("bresp", 32'(BRESP), 32'(e.resp));
        end else begin
            check("b_scoreboard_nonempty", 32'(b_q.size()), 32'd1);
        end
        for (int h = 0; h < hold; h++) begin
            check("bvalid_hold", 32'(BVALID), 32'h1);
            check("bresp_hold", 32'(BRESP), 32'(e.resp));
            check("awready_hold", 32'(AWREADY), 32'h0);
            check("wready_hold", 32'(WREADY), 32'h0);
            @(negedge ACLK);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        check("bvalid_clear", 32'(BVALID), 32'h0);
        check("awready_back", 32'(AWREADY), 32'h1);
        check("wready_back", 32'(WREADY), 32'h1);
        @(negedge ACLK);
        check_regs("reg_q_after_write");
        check("pulse_total", 32'(pulse_total - tot0), ok ? 32'd1 : 32'd0);
        if (ok) check("pulse_idx", 32'(pulse_cnt[idx] - cnt0), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic hs, done;
        int   lat;
        exp_t e;
        e.resp = exp_resp;
        e.data = exp_data;
        r_q.push_back(e);
        ARADDR = addr;
        done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            ARVALID = 1'b1;
            hs = ARVALID && ARREADY;
            @(negedge ACLK);
            if (hs) begin ARVALID = 1'b0; done = 1'b1; end
        end
        ARVALID = 1'b0;
        check("ar_handshake", 32'(done), 32'h1);
        lat = 0;
        while (!RVALID && lat < 20) begin
            @(negedge ACLK);
            lat++;
        end
        check("r_latency", 32'(lat), 32'd1);
        if (r_q.size() > 0) begin
            e = r_q.pop_front();
            check("rdata", RDATA, e.data);
            check("rresp", 32'(RRESP), 32'(e.resp));
        end else begin
            check("r_scoreboard_nonempty", 32'(r_q.size()), 32'd1);
        end
        for (int h = 0; h < hold; h++) begin
            check("rvalid_hold", 32'(RVALID), 32'h1);
            check("rdata_hold", RDATA, e.data);
            check("arready_hold", 32'(ARREADY), 32'h0);
            @(negedge ACLK);
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        check("rvalid_clear", 32'(RVALID), 32'h0);
        check("arready_back", 32'(ARREADY), 32'h1);
    endtask

    vec_t vecs [16];
    exp_t eb, er;

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0,  0, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 0,  0, 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'h0000_AB00, 4'h2, 3,  0, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 0,  0, 2'b00, 32'hDEAD_ABEF};
        vecs[4]  = '{1'b1, 32'h0000_0040, 32'h1111_1111, 4'hF, 0,  0, 2'b10, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 0,  0, 2'b10, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0008, 32'h0000_0001, 4'hF, 0,  5, 2'b00, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 0,  5, 2'b00, 32'h0000_0001};
        vecs[8]  = '{1'b1, 32'h0000_003C, 32'h1234_5678, 4'h9, 0,  0, 2'b00, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_003F, 32'h0,         4'h0, 0,  0, 2'b00, 32'h1200_0078};
        vecs[10] = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'h0, 0,  0, 2'b00, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 0,  0, 2'b00, 32'h0};
        vecs[12] = '{1'b0, 32'h1000_0004, 32'h0,         4'h0, 0,  0, 2'b10, 32'h0};
        vecs[13] = '{1'b1, 32'h8000_0000, 32'h5555_5555, 4'hF, 0,  0, 2'b10, 32'h0};
        vecs[14] = '{1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'hF, -2, 0, 2'b00, 32'h0};
        vecs[15] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 0,  0, 2'b00, 32'hCAFE_F00D};

        ARESET = 1'b1;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        repeat (2) @(negedge ACLK);
        check("reset_awready", 32'(AWREADY), 32'h1);
        check("reset_wready", 32'(WREADY), 32'h1);
        check("reset_arready", 32'(ARREADY), 32'h1);
        check("reset_bvalid", 32'(BVALID), 32'h0);
        check("reset_rvalid", 32'(RVALID), 32'h0);
        check("reset_bresp", 32'(BRESP), 32'h0);
        check("reset_rresp", 32'(RRESP), 32'h0);
        check("reset_rdata", RDATA, 32'h0);
        check("reset_reg_wr", 32'(reg_wr), 32'h0);
        check_regs("reset_reg_q");
        ARESET = 1'b0;
        @(negedge ACLK);

        for (int v = 0; v < 16; v++) begin
            if (vecs[v].wr) do_write(vecs[v].addr, vecs[v].data, vecs[v].strb,
                                     vecs[v].lead, vecs[v].hold, vecs[v].resp);
            else            do_read(vecs[v].addr, vecs[v].hold, vecs[v].rdata, vecs[v].resp);
        end

        // Write and read of reg 2 handshaking on the same edge: read returns the old value.
        eb.resp = 2'b00; eb.data = 32'h0;
        er.resp = 2'b00; er.data = 32'h0000_0001;
        b_q.push_back(eb);
        r_q.push_back(er);
        model[2] = 32'h0000_0002;
        AWADDR = 32'h8; WDATA = 32'h2; WSTRB = 4'hF; ARADDR = 32'h8;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("rw_same_bvalid_early", 32'(BVALID), 32'h0);
        check("rw_same_rvalid_early", 32'(RVALID), 32'h0);
        @(negedge ACLK);
        check("rw_same_bvalid", 32'(BVALID), 32'h1);
        check("rw_same_rvalid", 32'(RVALID), 32'h1);
        eb = b_q.pop_front();
        er = r_q.pop_front();
        check("rw_same_bresp", 32'(BRESP), 32'(eb.resp));
        check("rw_same_rdata_old", RDATA, er.data);
        check("rw_same_reg2_new", reg_q[32*2 +: 32], 32'h0000_0002);
        BREADY = 1'b1; RREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0; RREADY = 1'b0;
        check_regs("rw_same_reg_q");
        do_read(32'h8, 0, 32'h0000_0002, 2'b00);

        // Reset while the write response is pending aborts it.
        AWADDR = 32'h10; WDATA = 32'h55; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK);
        check("wresp_pending_bvalid", 32'(BVALID), 32'h1);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        check("abort_bvalid", 32'(BVALID), 32'h0);
        check("abort_awready", 32'(AWREADY), 32'h1);
        check("abort_wready", 32'(WREADY), 32'h1);
        check_regs("abort_reg_q");
        @(negedge ACLK);
        do_read(32'h4, 0, 32'h0, 2'b00);
        do_write(32'h18, 32'h0BAD_F00D, 4'hC, 1, 0, 2'b00);
        do_read(32'h18, 0, 32'h0BAD_0000, 2'b00);

        check("b_scoreboard_empty", 32'(b_q.size()), 32'h0);
        check("r_scoreboard_empty", 32'(r_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
